// File: rtl/pwm_capture.sv
// PWM input capture: measures high time and period (rise to rise) of pwm_in_i in clk cycles.
// Optional glitch filter enabled by defining PWM_CAP_GLITCH_FILT_EN.
module pwm_capture #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             pwm_in_i,
  output logic [CNT_W-1:0] high_cnt_o,
  output logic [CNT_W-1:0] period_cnt_o,
  output logic             meas_valid_o,
  output logic             timeout_o,
  output logic             stuck_level_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  logic sync1_q, sync2_q, prev_q;
  logic level_s, rise_s, fall_s;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_inc_d, hold_q;
  logic [CNT_W-1:0] high_cnt_q, period_cnt_q;
  logic             meas_valid_q, timeout_q, stuck_level_q;

  // Two-flop synchroniser for the asynchronous PWM input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_CAP_GLITCH_FILT_EN
  logic hist1_q, hist2_q, filt_q;

  // Level follows the input only once three consecutive samples agree.
  always_comb begin
    level_s = filt_q;
    if ((sync2_q == hist1_q) && (hist1_q == hist2_q)) begin
      level_s = sync2_q;
    end else begin
      level_s = filt_q;
    end
  end

  // Sample history and filtered-level storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist1_q <= 1'b0;
      hist2_q <= 1'b0;
      filt_q  <= 1'b0;
    end else begin
      hist1_q <= sync2_q;
      hist2_q <= hist1_q;
      filt_q  <= level_s;
    end
  end
`else
  assign level_s = sync2_q;
`endif

  // Previous-level register for the edge detector.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level_s;
    end
  end

  assign rise_s = level_s & ~prev_q;
  assign fall_s = ~level_s & prev_q;

  // Saturating increment: the counter never wraps.
  always_comb begin
    if (cnt_q == CNT_MAX) begin
      cnt_inc_d = CNT_MAX;
    end else begin
      cnt_inc_d = cnt_q + CNT_ONE;
    end
  end

  // Measurement FSM; an expected edge takes priority over the timeout limit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      cnt_q         <= CNT_ZERO;
      hold_q        <= CNT_ZERO;
      high_cnt_q    <= CNT_ZERO;
      period_cnt_q  <= CNT_ZERO;
      meas_valid_q  <= 1'b0;
      timeout_q     <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      if (!enable_i) begin
        state_q <= ST_IDLE;
        cnt_q   <= CNT_ZERO;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rise_s) begin
              state_q <= ST_HIGH;
              cnt_q   <= CNT_ONE;
            end
          end
          ST_HIGH: begin
            if (fall_s) begin
              state_q <= ST_LOW;
              hold_q  <= cnt_q;
              cnt_q   <= cnt_inc_d;
            end else if (cnt_q == CNT_MAX) begin
              state_q       <= ST_IDLE;
              cnt_q         <= CNT_ZERO;
              timeout_q     <= 1'b1;
              stuck_level_q <= level_s;
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
          ST_LOW: begin
            if (rise_s) begin
              state_q      <= ST_HIGH;
              high_cnt_q   <= hold_q;
              period_cnt_q <= cnt_q;
              meas_valid_q <= 1'b1;
              timeout_q    <= 1'b0;
              cnt_q        <= CNT_ONE;
            end else if (cnt_q == CNT_MAX) begin
              state_q       <= ST_IDLE;
              cnt_q         <= CNT_ZERO;
              timeout_q     <= 1'b1;
              stuck_level_q <= level_s;
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
          end
        endcase
      end
    end
  end

  assign high_cnt_o    = high_cnt_q;
  assign period_cnt_o  = period_cnt_q;
  assign meas_valid_o  = meas_valid_q;
  assign timeout_o     = timeout_q;
  assign stuck_level_o = stuck_level_q;

endmodule
